m_conv_kxk_stream: RTL and testbench

- Parametrised successor to the fixed 9x9 single-channel conv stage.
- Streams one IMG_W x IMG_H frame, raster order, one pixel per in_valid.
- Computes a valid-only (no padding) KxK convolution with run-time loadable coefficients and bias, rounding and saturation.
- Emits results with an explicit valid strobe, so downstream pooling/next-conv stages need no cycle-count masking.

---
 rtl/m_conv_kxk_stream_if.sv | 28 ++
 rtl/m_conv_kxk_stream.sv | 234 +++++++++++++++++++++++
 tb/tb_m_conv_kxk_stream.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/m_conv_kxk_stream_if.sv
// m_conv_kxk_stream_if: control, pixel stream, coefficient load and result
// stream of the KxK convolution stage, bundled so that producer and
// consumer see one port.
interface m_conv_kxk_stream_if #(
    parameter int DW = 16,
    parameter int CW = 7
);
    logic                 start;
    logic                 in_valid;
    logic signed [DW-1:0] in_data;
    logic                 coef_we;
    logic [CW-1:0]        coef_addr;
    logic signed [DW-1:0] coef_data;
    logic                 out_valid;
    logic signed [DW-1:0] out_data;
    logic                 busy;
    logic                 frame_done;

    modport master (
        output start, in_valid, in_data, coef_we, coef_addr, coef_data,
        input  out_valid, out_data, busy, frame_done
    );

    modport slave (
        input  start, in_valid, in_data, coef_we, coef_addr, coef_data,
        output out_valid, out_data, busy, frame_done
    );
endinterface

// File: rtl/m_conv_kxk_stream.sv
// m_conv_kxk_stream: streams one IMG_W x IMG_H raster frame and computes a
// valid-only KxK convolution with loadable coefficients and bias, rounding
// half-up and saturating to DW bits. Results leave a 4-stage pipeline tagged
// with out_valid.
// Optional build macro CONV_RELU_EN: clamp negative results to zero.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; coefficient/bias writes accepted
// RUN   | accepting in_valid pixels, shifting the line buffer
// FLUSH | 4 cycles draining the pipeline after the last pixel
// DONE  | 1 cycle, frame_done pulse
module m_conv_kxk_stream #(
    parameter int IMG_W = 96,
    parameter int IMG_H = 96,
    parameter int K     = 9,
    parameter int DW    = 16,
    parameter int FRAC  = 12,
    parameter int CW    = $clog2(K*K+1)
) (
    input  logic               clk_in,
    input  logic               rst_n,
    m_conv_kxk_stream_if.slave bus
);
    localparam int NT       = K*K;
    localparam int LB_DEPTH = (K-1)*IMG_W + K;    // window span incl. incoming pixel
    localparam int HD       = (LB_DEPTH > 1) ? LB_DEPTH - 1 : 1;
    localparam int XW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW       = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int PW       = 2*DW;
    localparam int SW       = PW + $clog2(K) + 1;
    localparam int AW       = PW + $clog2(NT);
    localparam int FLUSH_CYC = 4;

    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic                 busy_d, done_d;
    logic [XW-1:0]        col_q;
    logic [YW-1:0]        row_q;
    logic [1:0]           flush_cnt_q;

    logic signed [DW-1:0] coef_q [NT];
    logic signed [DW-1:0] bias_q;
    logic signed [DW-1:0] hist_q [HD];
    logic signed [DW-1:0] tap    [LB_DEPTH];
    logic signed [DW-1:0] win    [NT];

    logic                 accept, col_last, row_last, last_pix, win_done;

    logic signed [PW-1:0] prod_q [NT];
    logic signed [SW-1:0] rsum_d [K];
    logic signed [SW-1:0] rsum_q [K];
    logic signed [AW-1:0] acc_d, acc_q;
    logic signed [AW-1:0] shifted;
    logic signed [DW-1:0] res_d;
    logic signed [DW-1:0] out_data_q;
    logic                 v1_q, v2_q, v3_q, out_valid_q;

    assign accept   = (state_q == S_RUN) && bus.in_valid;
    assign col_last = (int'(col_q) == IMG_W-1);
    assign row_last = (int'(row_q) == IMG_H-1);
    assign last_pix = accept && col_last && row_last;
    assign win_done = accept && (int'(row_q) >= K-1) && (int'(col_q) >= K-1);

    // State register.
    always_ff @(posedge clk_in) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode and Moore outputs.
    always_comb begin
        state_d = state_q;
        busy_d  = 1'b1;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (bus.start) state_d = S_RUN;
            end
            S_RUN: begin
                if (last_pix) state_d = S_FLUSH;
            end
            S_FLUSH: begin
                if (flush_cnt_q == 2'd0) state_d = S_DONE;
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Raster position counters and flush down-counter.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (state_q == S_IDLE && bus.start) begin
                col_q <= '0;
                row_q <= '0;
            end else if (accept) begin
                if (col_last) begin
                    col_q <= '0;
                    row_q <= row_last ? '0 : row_q + YW'(1);
                end else begin
                    col_q <= col_q + XW'(1);
                end
            end
            if (last_pix)
                flush_cnt_q <= 2'(FLUSH_CYC - 1);
            else if (state_q == S_FLUSH && flush_cnt_q != 2'd0)
                flush_cnt_q <= flush_cnt_q - 2'd1;
        end
    end

    // Coefficient and bias file; survives reset, writable only while idle.
    always_ff @(posedge clk_in) begin
        if (bus.coef_we && state_q == S_IDLE) begin
            if (int'(bus.coef_addr) < NT)
                coef_q[bus.coef_addr] <= bus.coef_data;
            else if (int'(bus.coef_addr) == NT)
                bias_q <= bus.coef_data;
        end
    end

    // Line buffer: history of the last LB_DEPTH-1 accepted pixels, newest at 0.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            for (int i = 0; i < HD; i++) hist_q[i] <= '0;
        end else if (accept) begin
            hist_q[0] <= bus.in_data;
            for (int i = 1; i < HD; i++) hist_q[i] <= hist_q[i-1];
        end
    end

    // Tap 0 is the pixel arriving this cycle so the window it completes
    // enters stage 1 on its own acceptance edge.
    always_comb begin
        tap[0] = bus.in_data;
        for (int i = 1; i < LB_DEPTH; i++) tap[i] = hist_q[i-1];
    end

    // KxK window: win[r*K+c] is row r, column c with [0] the oldest pixel.
    always_comb begin
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                win[r*K+c] = tap[(K-1-r)*IMG_W + (K-1-c)];
    end

    // Stage 1: full-width products.
    always_ff @(posedge clk_in) begin
        for (int i = 0; i < NT; i++)
            prod_q[i] <= PW'(coef_q[i]) * PW'(win[i]);
    end

    // Valid tags travel alongside the data stages.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            v3_q        <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            v1_q        <= win_done;
            v2_q        <= v1_q;
            v3_q        <= v2_q;
            out_valid_q <= v3_q;
        end
    end

    // Stage 2 adders: one sum per kernel row.
    always_comb begin
        for (int r = 0; r < K; r++) begin
            rsum_d[r] = '0;
            for (int c = 0; c < K; c++)
                rsum_d[r] = rsum_d[r] + SW'(prod_q[r*K+c]);
        end
    end

    // Stage 2 register.
    always_ff @(posedge clk_in) begin
        for (int r = 0; r < K; r++) rsum_q[r] <= rsum_d[r];
    end

    // Stage 3 adders: total plus bias aligned to the product scale plus half an LSB.
    always_comb begin
        acc_d = (AW'(bias_q) <<< FRAC) + (AW'(1) <<< (FRAC-1));
        for (int r = 0; r < K; r++)
            acc_d = acc_d + AW'(rsum_q[r]);
    end

    // Stage 3 register.
    always_ff @(posedge clk_in) begin
        acc_q <= acc_d;
    end

    // Stage 4 logic: floor shift (half-up with the added half), saturate, optional ReLU.
    always_comb begin
        shifted = acc_q >>> FRAC;
        if (shifted > SAT_MAX)
            res_d = {1'b0, {(DW-1){1'b1}}};
        else if (shifted < SAT_MIN)
            res_d = {1'b1, {(DW-1){1'b0}}};
        else
            res_d = shifted[DW-1:0];
`ifdef CONV_RELU_EN
        if (res_d[DW-1]) res_d = '0;
`endif
    end

    // Stage 4 register; holds its last result between valid strobes.
    always_ff @(posedge clk_in) begin
        if (!rst_n)    out_data_q <= '0;
        else if (v3_q) out_data_q <= res_d;
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.busy       = busy_d;
    assign bus.frame_done = done_d;
endmodule

// File: tb/tb_m_conv_kxk_stream.sv
// tb_m_conv_kxk_stream: table-driven uniform-frame vectors, hand-written
// latency/abort/stall sequences and randomized frames against a direct
// arithmetic convolution reference.
module tb_m_conv_kxk_stream;
    localparam int IMG_W = 8;
    localparam int IMG_H = 8;
    localparam int K     = 3;
    localparam int DW    = 16;
    localparam int FRAC  = 12;
    localparam int CW    = 4;
    localparam int NT    = K*K;
    localparam int NOUT  = (IMG_W-K+1)*(IMG_H-K+1);

    logic clk_in = 1'b0;
    logic rst_n  = 1'b0;
    always #5 clk_in = ~clk_in;

    m_conv_kxk_stream_if #(.DW(DW), .CW(CW)) bus ();

    m_conv_kxk_stream #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .DW(DW), .FRAC(FRAC), .CW(CW)
    ) dut (
        .clk_in(clk_in),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total  = 0;
    int passed = 0;
    int cyc    = 0;

    int obs_d[$];
    int obs_c[$];
    int fd_q[$];
    int exp_q[$];

    int tcoef[NT];
    int tbias;
    int pix[IMG_H][IMG_W];
    int p22_cyc;
    int last_cyc;

    typedef struct {
        int ckind;   // 0: all coefficients = cval, 1: coef[0] = cval, rest 0
        int cval;
        int bias;
        int pval;
        int gap;
        int expv;
    } vec_t;
    vec_t vt[7];

    always @(posedge clk_in) cyc <= cyc + 1;

    always @(posedge clk_in) begin
        #1;
        if (bus.out_valid === 1'b1) begin
            obs_d.push_back(int'(bus.out_data));
            obs_c.push_back(cyc);
        end
        if (bus.frame_done === 1'b1) fd_q.push_back(cyc);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_in);
        #2;
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic set_coef(input int addr, input int val);
        bus.coef_we   = 1'b1;
        bus.coef_addr = CW'(addr);
        bus.coef_data = DW'(val);
        tick();
        bus.coef_we = 1'b0;
        if (addr < NT) tcoef[addr] = val;
        else if (addr == NT) tbias = val;
    endtask

    function automatic int ref_out(input int r, input int c);
        longint s;
        s = 0;
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                s += longint'(tcoef[i*K+j]) * longint'(pix[r+i][c+j]);
        s += longint'(tbias) * (longint'(1) << FRAC) + (longint'(1) << (FRAC-1));
        s = s >>> FRAC;
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
`ifdef CONV_RELU_EN
        if (s < 0) s = 0;
`endif
        return int'(s);
    endfunction

    function automatic void build_expected();
        exp_q.delete();
        for (int r = 0; r <= IMG_H-K; r++)
            for (int c = 0; c <= IMG_W-K; c++)
                exp_q.push_back(ref_out(r, c));
    endfunction

    task automatic run_frame(input int gap_mode, input bit wr_in_run);
        int ng;
        int idx;
        obs_d.delete(); obs_c.delete(); fd_q.delete();
        bus.in_valid = 1'b1;
        bus.in_data  = DW'($urandom);
        tick();
        bus.in_valid = 1'b0;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int r = 0; r < IMG_H; r++) begin
            for (int c = 0; c < IMG_W; c++) begin
                ng = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
                for (int g = 0; g < ng; g++) begin
                    bus.in_valid = 1'b0;
                    bus.start    = 1'b0;
                    bus.coef_we  = 1'b0;
                    bus.in_data  = DW'($urandom);
                    tick();
                end
                idx = r*IMG_W + c;
                bus.in_valid = 1'b1;
                bus.in_data  = DW'(pix[r][c]);
                bus.start    = (idx == 20);
                bus.coef_we  = 1'b0;
                if (wr_in_run && idx == 10) begin
                    bus.coef_we = 1'b1; bus.coef_addr = CW'(4); bus.coef_data = DW'(0);
                end
                if (wr_in_run && idx == 11) begin
                    bus.coef_we = 1'b1; bus.coef_addr = CW'(NT); bus.coef_data = DW'(100);
                end
                if (r == K-1 && c == K-1) p22_cyc = cyc;
                if (r == IMG_H-1 && c == IMG_W-1) last_cyc = cyc;
                tick();
            end
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        bus.coef_we  = 1'b0;
        for (int w = 0; w < 40 && fd_q.size() == 0; w++) tick();
        tick();
        tick();
    endtask

    task automatic verify_frame(input string name, input bit use_const, input int cval);
        build_expected();
        check($sformatf("%s out count", name), obs_d.size(), NOUT);
        for (int i = 0; i < NOUT && i < obs_d.size(); i++)
            check($sformatf("%s out[%0d]", name, i), obs_d[i], use_const ? cval : exp_q[i]);
        check($sformatf("%s last out cycle", name),
              (obs_c.size() > 0) ? obs_c[obs_c.size()-1] : -1, last_cyc + 4);
        check($sformatf("%s frame_done cycle", name),
              (fd_q.size() == 1) ? fd_q[0] : -1, last_cyc + 5);
    endtask

    task automatic random_setup();
        for (int i = 0; i < NT; i++) set_coef(i, int'($urandom_range(0, 4095)) - 2048);
        set_coef(NT, int'($urandom_range(0, 200)) - 100);
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++)
                pix[r][c] = int'($urandom_range(0, 16383)) - 8192;
    endtask

    initial begin
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
        bus.coef_we = 1'b0; bus.coef_addr = '0; bus.coef_data = '0;
        for (int i = 0; i < NT; i++) tcoef[i] = 0;
        tbias = 0;

        vt[0] = '{0, 4096,  0,      1, 0,      9};
        vt[1] = '{0, 4096,  0,      1, 1,      9};
        vt[2] = '{1, 2048,  0,      3, 0,      2};
        vt[3] = '{1, 2048,  0,     -3, 0,     -1};
        vt[4] = '{0,    0,  5,      0, 0,      5};
        vt[5] = '{0, 32767, 0,  32767, 0,  32767};
`ifdef CONV_RELU_EN
        vt[6] = '{0, 32767, 0, -32768, 0,      0};
`else
        vt[6] = '{0, 32767, 0, -32768, 0, -32768};
`endif

        // power-up reset with in_valid toggling
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = (i % 2 == 0);
            tick();
        end
        bus.in_valid = 1'b0;
        check("reset out_valid", int'(bus.out_valid), 0);
        check("reset out_data", int'(bus.out_data), 0);
        check("reset busy", int'(bus.busy), 0);
        check("reset frame_done", int'(bus.frame_done), 0);
        rst_n = 1'b1;
        tick();

        // coefficients loaded before a reset must survive it
        for (int i = 0; i < NT; i++) set_coef(i, 4096);
        set_coef(NT, 0);
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = (i % 2 == 1);
            bus.in_data  = DW'(7);
            tick();
        end
        bus.in_valid = 1'b0;
        check("reset2 out_valid", int'(bus.out_valid), 0);
        check("reset2 busy", int'(bus.busy), 0);
        rst_n = 1'b1;
        tick();
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++) pix[r][c] = 1;
        run_frame(0, 1'b0);
        verify_frame("retained", 1'b1, 9);

        // uniform-frame vector table
        for (int v = 0; v < 7; v++) begin
            for (int i = 0; i < NT; i++)
                set_coef(i, (vt[v].ckind == 0 || i == 0) ? vt[v].cval : 0);
            set_coef(NT, vt[v].bias);
            set_coef(12, 1234);
            set_coef(15, -777);
            for (int r = 0; r < IMG_H; r++)
                for (int c = 0; c < IMG_W; c++) pix[r][c] = vt[v].pval;
            run_frame(vt[v].gap, 1'b0);
            verify_frame($sformatf("vec%0d", v), 1'b1, vt[v].expv);
        end

        // identity kernel with first-output latency
        for (int i = 0; i < NT; i++) set_coef(i, (i == 4) ? 4096 : 0);
        set_coef(NT, 0);
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++) pix[r][c] = 8*r + c;
        run_frame(0, 1'b0);
        verify_frame("identity", 1'b0, 0);
        check("identity first out out[0]", (obs_d.size() > 0) ? obs_d[0] : -1, 9);
        check("identity latency", (obs_c.size() > 0) ? obs_c[0] : -1, p22_cyc + 4);

        // coefficient writes during RUN must be ignored
        run_frame(0, 1'b1);
        verify_frame("coef_we_in_run", 1'b0, 0);

        // abort mid-frame with reset at pixel 30
        random_setup();
        obs_d.delete(); obs_c.delete();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 30; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = DW'(pix[i / IMG_W][i % IMG_W]);
            tick();
        end
        check("abort busy before reset", int'(bus.busy), 1);
        rst_n = 1'b0;
        bus.in_data = DW'(pix[30 / IMG_W][30 % IMG_W]);
        tick();
        rst_n = 1'b1;
        obs_d.delete(); obs_c.delete();
        check("abort busy after reset", int'(bus.busy), 0);
        check("abort out_valid after reset", int'(bus.out_valid), 0);
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = (i % 2 == 0);
            bus.in_data  = DW'($urandom);
            tick();
        end
        bus.in_valid = 1'b0;
        check("abort no outputs until start", obs_d.size(), 0);
        random_setup();
        run_frame(2, 1'b0);
        verify_frame("after_abort", 1'b0, 0);

        // randomized frames with random stalls
        for (int n = 0; n < 3; n++) begin
            random_setup();
            run_frame(2, 1'b0);
            verify_frame($sformatf("random%0d", n), 1'b0, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
